// File: rtl/ctrl_hazard_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_hazard_if
//  Purpose  : Bundle of the ID-stage request, branch/memory status and the
//             hazard/forwarding responses exchanged with ctrl_hazard.
//  Ports    : master drives the i_* fields and observes the o_* fields;
//             slave (the hazard unit) does the reverse.
//  Revision : 1.0  initial release
// ============================================================================
interface ctrl_hazard_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              i_id_valid;
    logic [REG_AW-1:0] i_id_rs1;
    logic [REG_AW-1:0] i_id_rs2;
    logic              i_id_use_rs1;
    logic              i_id_use_rs2;
    logic [REG_AW-1:0] i_id_rd;
    logic              i_id_we;
    logic              i_id_load;
    logic              i_ex_branch_taken;
    logic              i_mem_busy;

    logic              o_stall_id;
    logic              o_bubble_ex;
    logic              o_flush_ifid;
    logic              o_freeze;
    logic [1:0]        o_fwd_a;
    logic [1:0]        o_fwd_b;
    logic              o_wb_we;
    logic [REG_AW-1:0] o_wb_rd;
    logic [CNT_W-1:0]  o_stall_cnt;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_id_rd, i_id_we, i_id_load, i_ex_branch_taken, i_mem_busy,
        input  o_stall_id, o_bubble_ex, o_flush_ifid, o_freeze, o_fwd_a,
               o_fwd_b, o_wb_we, o_wb_rd, o_stall_cnt
    );

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_id_rd, i_id_we, i_id_load, i_ex_branch_taken, i_mem_busy,
        output o_stall_id, o_bubble_ex, o_flush_ifid, o_freeze, o_fwd_a,
               o_fwd_b, o_wb_we, o_wb_rd, o_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_hazard.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_hazard
//  Purpose  : Hazard, forwarding and stall sequencer for the 4-stage
//             ID/EX/MEM/WB control path. Shadows rd/we/load of the EX, MEM
//             and WB slots and derives stall, bubble, flush, freeze and the
//             EX operand forwarding selects from that shadow.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-low reset
//             bus  - ctrl_hazard_if slave (ID request, branch/busy status,
//                    stall/flush/freeze/forwarding/WB/counter outputs)
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_hazard #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    ctrl_hazard_if.slave   bus
);

    localparam logic [CNT_W-1:0]  c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [REG_AW-1:0] c_r0      = '0;

    // EX slot keeps the source fields too: forwarding selects are resolved
    // for the instruction currently sitting in EX.
    logic              ex_valid_q, ex_we_q, ex_load_q, ex_use1_q, ex_use2_q;
    logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic              mem_valid_q, mem_we_q, mem_load_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_valid_q, wb_we_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic w_ex_qual, w_mem_qual, w_wb_qual;
    logic w_luh, w_ex_take;

    assign w_ex_qual  = ex_valid_q  & ex_we_q  & (ex_rd_q  != c_r0);
    assign w_mem_qual = mem_valid_q & mem_we_q & (mem_rd_q != c_r0);
    assign w_wb_qual  = wb_valid_q  & wb_we_q  & (wb_rd_q  != c_r0);

    assign w_luh = bus.i_id_valid & w_ex_qual & ex_load_q &
                   (((ex_rd_q == bus.i_id_rs1) & bus.i_id_use_rs1) |
                    ((ex_rd_q == bus.i_id_rs2) & bus.i_id_use_rs2));

    // ID enters EX unless a bubble is being inserted (load-use or branch).
    assign w_ex_take = bus.i_id_valid & ~(w_luh | bus.i_ex_branch_taken);

    always_comb begin
        cnt_d = cnt_q;
        if (w_luh && !bus.i_ex_branch_taken && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            cnt_q       <= '0;
        end else if (!bus.i_mem_busy) begin
            wb_valid_q  <= mem_valid_q;
            wb_we_q     <= mem_we_q;
            wb_rd_q     <= mem_rd_q;
            mem_valid_q <= ex_valid_q;
            mem_we_q    <= ex_we_q;
            mem_load_q  <= ex_load_q;
            mem_rd_q    <= ex_rd_q;
            cnt_q       <= cnt_d;
            if (w_ex_take) begin
                ex_valid_q <= 1'b1;
                ex_we_q    <= bus.i_id_we;
                ex_load_q  <= bus.i_id_load;
                ex_use1_q  <= bus.i_id_use_rs1;
                ex_use2_q  <= bus.i_id_use_rs2;
                ex_rd_q    <= bus.i_id_rd;
                ex_rs1_q   <= bus.i_id_rs1;
                ex_rs2_q   <= bus.i_id_rs2;
            end else begin
                // Bubble: zeroed fields so it can never match a source.
                ex_valid_q <= 1'b0;
                ex_we_q    <= 1'b0;
                ex_load_q  <= 1'b0;
                ex_use1_q  <= 1'b0;
                ex_use2_q  <= 1'b0;
                ex_rd_q    <= '0;
                ex_rs1_q   <= '0;
                ex_rs2_q   <= '0;
            end
        end
    end

    // Input-driven outputs are masked by rst so every output reads 0 while
    // reset is held; slot-driven outputs are already 0 from the cleared state.
    assign bus.o_freeze     = rst & bus.i_mem_busy;
    assign bus.o_flush_ifid = rst & bus.i_ex_branch_taken & ~bus.i_mem_busy;
    assign bus.o_stall_id   = rst & ((w_luh & ~bus.i_ex_branch_taken) |
                                     bus.i_mem_busy);
    assign bus.o_bubble_ex  = rst & (w_luh | bus.i_ex_branch_taken) &
                              ~bus.i_mem_busy;

    // A load in MEM never forwards from EX/MEM: the load-use stall has
    // already pushed its data into WB by the time a consumer reaches EX.
    assign bus.o_fwd_a =
        (w_mem_qual & ~mem_load_q & (mem_rd_q == ex_rs1_q) & ex_use1_q) ? 2'b01 :
        (w_wb_qual & (wb_rd_q == ex_rs1_q))                             ? 2'b10 :
                                                                          2'b00;
    assign bus.o_fwd_b =
        (w_mem_qual & ~mem_load_q & (mem_rd_q == ex_rs2_q) & ex_use2_q) ? 2'b01 :
        (w_wb_qual & (wb_rd_q == ex_rs2_q))                             ? 2'b10 :
                                                                          2'b00;

    assign bus.o_wb_we     = w_wb_qual;
    assign bus.o_wb_rd     = wb_rd_q;
    assign bus.o_stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_hazard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_hazard
//  Purpose  : Self-checking bench for ctrl_hazard. Two instances share one
//             stimulus stream: the default 16-bit counter and a 2-bit counter
//             that exercises saturation. Directed scenarios are followed by
//             random traffic, all compared against a pipeline-record model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_hazard;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_hazard_if #(.REG_AW(4), .CNT_W(16)) bus_a ();
    ctrl_hazard_if #(.REG_AW(4), .CNT_W(2))  bus_s ();

    ctrl_hazard #(.REG_AW(4), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    ctrl_hazard #(.REG_AW(4), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    // One record per in-flight instruction: index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit [3:0] rd;
        bit       we;
        bit       ld;
        bit [3:0] rs1;
        bit [3:0] rs2;
        bit       u1;
        bit       u2;
    } rec_t;

    rec_t        pipe [3];
    rec_t        id_rec;
    bit          t_br, t_busy;
    int unsigned cnt_a, cnt_s;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(input rec_t r);
        return r.v && r.we && (r.rd != 4'd0);
    endfunction

    function automatic bit m_luh();
        return id_rec.v && writes(pipe[0]) && pipe[0].ld &&
               ((pipe[0].rd == id_rec.rs1 && id_rec.u1) ||
                (pipe[0].rd == id_rec.rs2 && id_rec.u2));
    endfunction

    function automatic logic [1:0] m_fwd(input bit [3:0] rs, input bit u);
        if (writes(pipe[1]) && !pipe[1].ld && pipe[1].rd == rs && u) return 2'b01;
        if (writes(pipe[2]) && pipe[2].rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        cnt_a = 0;
        cnt_s = 0;
    endtask

    task automatic model_advance();
        bit luh;
        luh = m_luh();
        if (!t_busy) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (id_rec.v && !luh && !t_br) pipe[0] = id_rec;
            else                           pipe[0] = '{default: 0};
            if (luh && !t_br) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_s < 3)     cnt_s++;
            end
        end
    endtask

    task automatic check_all();
        bit luh;
        logic stall, bub, flush, frz, wbwe;
        logic [1:0] fa, fb;
        logic [3:0] wbrd;
        luh   = m_luh();
        stall = rst & ((luh & !t_br) | t_busy);
        bub   = rst & (luh | t_br) & !t_busy;
        flush = rst & t_br & !t_busy;
        frz   = rst & t_busy;
        fa    = rst ? m_fwd(pipe[0].rs1, pipe[0].u1) : 2'b00;
        fb    = rst ? m_fwd(pipe[0].rs2, pipe[0].u2) : 2'b00;
        wbwe  = rst & writes(pipe[2]);
        wbrd  = rst ? pipe[2].rd : 4'd0;
        chk("a.stall",  bus_a.o_stall_id,   stall);
        chk("a.bubble", bus_a.o_bubble_ex,  bub);
        chk("a.flush",  bus_a.o_flush_ifid, flush);
        chk("a.freeze", bus_a.o_freeze,     frz);
        chk("a.fwd_a",  bus_a.o_fwd_a,      fa);
        chk("a.fwd_b",  bus_a.o_fwd_b,      fb);
        chk("a.wb_we",  bus_a.o_wb_we,      wbwe);
        chk("a.wb_rd",  bus_a.o_wb_rd,      wbrd);
        chk("a.cnt",    bus_a.o_stall_cnt,  rst ? cnt_a : 0);
        chk("s.stall",  bus_s.o_stall_id,   stall);
        chk("s.fwd_a",  bus_s.o_fwd_a,      fa);
        chk("s.cnt",    bus_s.o_stall_cnt,  rst ? cnt_s : 0);
    endtask

    task automatic apply_inputs();
        bus_a.i_id_valid        = id_rec.v;
        bus_a.i_id_rs1          = id_rec.rs1;
        bus_a.i_id_rs2          = id_rec.rs2;
        bus_a.i_id_use_rs1      = id_rec.u1;
        bus_a.i_id_use_rs2      = id_rec.u2;
        bus_a.i_id_rd           = id_rec.rd;
        bus_a.i_id_we           = id_rec.we;
        bus_a.i_id_load         = id_rec.ld;
        bus_a.i_ex_branch_taken = t_br;
        bus_a.i_mem_busy        = t_busy;
        bus_s.i_id_valid        = id_rec.v;
        bus_s.i_id_rs1          = id_rec.rs1;
        bus_s.i_id_rs2          = id_rec.rs2;
        bus_s.i_id_use_rs1      = id_rec.u1;
        bus_s.i_id_use_rs2      = id_rec.u2;
        bus_s.i_id_rd           = id_rec.rd;
        bus_s.i_id_we           = id_rec.we;
        bus_s.i_id_load         = id_rec.ld;
        bus_s.i_ex_branch_taken = t_br;
        bus_s.i_mem_busy        = t_busy;
    endtask

    // Drive one cycle of inputs on the falling edge and check all outputs.
    task automatic drive(input bit v, input bit [3:0] rs1, input bit [3:0] rs2,
                         input bit u1, input bit u2, input bit [3:0] rd,
                         input bit we, input bit ld, input bit br, input bit busy);
        @(negedge clk);
        id_rec.v  = v;   id_rec.rs1 = rs1; id_rec.rs2 = rs2;
        id_rec.u1 = u1;  id_rec.u2  = u2;  id_rec.rd  = rd;
        id_rec.we = we;  id_rec.ld  = ld;
        t_br = br;
        t_busy = busy;
        apply_inputs();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_advance();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        id_rec = '{default: 0};
        t_br = 0;
        t_busy = 0;
        apply_inputs();
        // Reset held: every output 0 even with busy/branch asserted.
        drive(1, 1, 2, 1, 1, 3, 1, 0, 1, 1); tick();
        idle(); tick();
        @(negedge clk);
        rst = 1'b1;

        // ALU chain: back-to-back -> EX/MEM forward on both operands.
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0); tick();
        idle();
        chk("alu.fwd_a_01", bus_a.o_fwd_a, 2'b01);
        chk("alu.fwd_b_01", bus_a.o_fwd_b, 2'b01);
        chk("alu.nostall", bus_a.o_stall_id, 1'b0);
        tick();
        // One unrelated instruction between -> MEM/WB forward.
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        drive(1, 10, 11, 1, 1, 9, 1, 0, 0, 0); tick();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0); tick();
        idle();
        chk("alu.fwd_a_10", bus_a.o_fwd_a, 2'b10);
        chk("alu.fwd_b_10", bus_a.o_fwd_b, 2'b10);
        tick();

        // Load-use: single-cycle stall, then WB forward on operand A.
        drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("lu.stall", bus_a.o_stall_id, 1'b1);
        chk("lu.bubble", bus_a.o_bubble_ex, 1'b1);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("lu.stall_once", bus_a.o_stall_id, 1'b0);
        chk("lu.cnt1", bus_a.o_stall_cnt, 1);
        tick();
        idle();
        chk("lu.fwd_a", bus_a.o_fwd_a, 2'b10);
        chk("lu.fwd_b", bus_a.o_fwd_b, 2'b00);
        tick();

        // Branch beats load-use stall.
        drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
        chk("br.stall", bus_a.o_stall_id, 1'b0);
        chk("br.flush", bus_a.o_flush_ifid, 1'b1);
        chk("br.bubble", bus_a.o_bubble_ex, 1'b1);
        tick();
        idle();
        chk("br.cnt", bus_a.o_stall_cnt, 1);
        tick();

        // Freeze during a load-use stall, then completion.
        drive(1, 1, 2, 1, 0, 7, 1, 1, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 2, 1, 1, 8, 1, 0, 0, 1);
            chk("frz.freeze", bus_a.o_freeze, 1'b1);
            chk("frz.stall", bus_a.o_stall_id, 1'b1);
            chk("frz.bubble", bus_a.o_bubble_ex, 1'b0);
            tick();
        end
        drive(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
        chk("frz.rel_stall", bus_a.o_stall_id, 1'b1);
        tick();
        drive(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
        chk("frz.cnt2", bus_a.o_stall_cnt, 2);
        tick();

        // r0 destination: no stall, no forward, no WB write.
        drive(1, 1, 2, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
        chk("r0.nostall", bus_a.o_stall_id, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // Five load-use stalls: 2-bit counter saturates.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0); tick();
            drive(1, 1, 5, 1, 1, 6, 1, 0, 0, 0); tick();
            drive(1, 1, 5, 1, 1, 6, 1, 0, 0, 0); tick();
        end
        idle();
        chk("sat.cnt3", bus_s.o_stall_cnt, 3);
        chk("sat.cnt7", bus_a.o_stall_cnt, 7);
        tick();

        // Asynchronous reset mid-stream with MEM/WB occupied.
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        drive(1, 3, 2, 1, 1, 4, 1, 0, 0, 0); tick();
        drive(1, 4, 3, 1, 1, 5, 1, 1, 1, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst.wb_we", bus_a.o_wb_we, 1'b0);
        chk("rst.cnt", bus_a.o_stall_cnt, 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin idle(); tick(); end

        // Random traffic on a narrow register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) < 3);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_hazard.md
Name: ctrl_hazard

Overview:
- Hazard, forwarding and stall sequencer for the 4-stage ID/EX/MEM/WB pipeline control path.
- Keeps an internal shadow of the destination register, write-enable and load flag for each of the EX, MEM and WB slots.
- From that shadow it drives ID stall, EX bubble insertion, branch flush, memory-busy freeze and forwarding selects for the EX-stage ALU operands.
- Sits beside the per-stage control blocks and is instantiated in the top-level control wrapper.

Parameters:
REG_AW, 4, register address width (16 architectural registers; r0 reads zero and is never a hazard source).
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous active-low reset.
i_id_valid  in  1  ID holds a real instruction.
i_id_rs1  in  REG_AW  ID source register A.
i_id_rs2  in  REG_AW  ID source register B.
i_id_use_rs1  in  1  instruction reads rs1.
i_id_use_rs2  in  1  instruction reads rs2.
i_id_rd  in  REG_AW  ID destination register.
i_id_we  in  1  instruction writes rd.
i_id_load  in  1  instruction is a memory load.
i_ex_branch_taken  in  1  branch resolved taken in EX this cycle.
i_mem_busy  in  1  data memory not ready; pipeline must freeze.
o_stall_id  out  1  hold PC and IF/ID register.
o_bubble_ex  out  1  load NOP into ID/EX.
o_flush_ifid  out  1  invalidate IF/ID register.
o_freeze  out  1  hold every pipeline register.
o_fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
o_fwd_b  out  2  EX operand B source, same encoding.
o_wb_we  out  1  register-file write enable (WB slot).
o_wb_rd  out  REG_AW  register-file write address (WB slot).
o_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): all slots invalid with rd=0, we=0, load=0; stall counter is 0. While in reset, every output is 0.
- Each slot holds: valid, rd, we, load, rs1, rs2, use_rs1, use_rs2. A write hazard qualifies only when valid=1, we=1 and rd!=0.
- Load-use hazard (luh): i_id_valid=1, EX slot qualifies with load=1, and its rd matches (i_id_rs1 with i_id_use_rs1) or (i_id_rs2 with i_id_use_rs2).
- Combinational outputs (same cycle):
  - o_freeze = i_mem_busy.
  - o_flush_ifid = i_ex_branch_taken & ~i_mem_busy.
  - o_stall_id = (luh & ~i_ex_branch_taken) | i_mem_busy.
  - o_bubble_ex = (luh | i_ex_branch_taken) & ~i_mem_busy.
- Priority: freeze > branch flush > load-use stall. A taken branch kills the dependent ID instruction, so no stall is raised.
- Slot advance on the rising edge, only when i_mem_busy=0:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields if (i_id_valid & ~o_bubble_ex), otherwise an invalid bubble.
- While i_mem_busy=1: all slots hold their contents; the stall counter holds.
- Forwarding for operand A (operand B identical, using rs2/use_rs2):
  - 01 if the MEM slot qualifies, load=0, and its rd equals EX.rs1 with EX.use_rs1 set.
  - otherwise 10 if the WB slot qualifies and its rd equals EX.rs1.
  - otherwise 00.
  - MEM wins over WB. A load in MEM never selects 01; the load-use stall guarantees the data is already in WB.
- o_wb_we = WB.valid & WB.we & (WB.rd!=0); o_wb_rd = WB.rd. Both are combinational from the WB slot.
- Stall counter: increments by 1 on each edge where luh & ~i_ex_branch_taken & ~i_mem_busy; saturates at all-ones.
- A load-use stall lasts exactly 1 cycle. After the bubble the load sits in MEM, so luh clears.
- Back-to-back loads with chained use each stall once.

Test Plan:
1. Reset: assert rst=0 mid-stream with MEM and WB slots valid -> all outputs 0 immediately (asynchronous) and o_stall_cnt=0; after release with no valid ID input, slots remain invalid.
2. ALU chain: "add r3" then "sub r4,r3,r3" -> next cycle o_fwd_a=01 and o_fwd_b=01; with one unrelated instruction between them -> 10/10; no stalls.
3. Load-use: "load r5" then "add r6,r5,r1" -> o_stall_id=1 and o_bubble_ex=1 for exactly 1 cycle, o_stall_cnt=1; the add then enters EX with o_fwd_a=10, o_fwd_b=00.
4. Branch vs stall: load-use pair present while i_ex_branch_taken=1 -> o_stall_id=0, o_flush_ifid=1, o_bubble_ex=1, counter unchanged.
5. Freeze: i_mem_busy=1 for 3 cycles during a load-use stall -> o_freeze=1 and o_stall_id=1, slots and o_wb_rd unchanged, counter unchanged; on release the stall completes normally.
6. r0 and saturation: writes to r0 produce no forwarding, no stall and o_wb_we=0; with CNT_W=2, 5 load-use stalls -> o_stall_cnt=3.
